// File: rtl/writeback_arbiter_pkg.sv
// Shared widths and helpers for the writeback arbiter slice.
package writeback_arbiter_pkg;

  localparam int unsigned REGISTER_NUMBER_LOG = 5;
  localparam int unsigned REGISTER_NUMBER     = 1 << REGISTER_NUMBER_LOG;
  localparam int unsigned DATA_WIDTH          = 32;
  localparam int unsigned LONG_FIFO_DEPTH     = 4;
  localparam int unsigned STARVE_LIMIT        = 8;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// Generic synchronous FIFO with per-slot valid bits and a flat index view.
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned WIDTH   = 37,
  parameter int unsigned INDEX_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [clog2(DEPTH):0]    count,
  output logic [DEPTH-1:0]         entry_valid,
  output logic [DEPTH*INDEX_W-1:0] entry_index
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Overflowing pushes and underflowing pops are dropped.
  assign push_ok   = push && (count < CNT_W'(DEPTH));
  assign pop_ok    = pop && (count != '0);
  assign head_data = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr]         <= push_data;
        entry_valid[wr_ptr] <= 1'b1;
        wr_ptr              <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        entry_valid[rd_ptr] <= 1'b0;
        rd_ptr              <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Index field (top bits of each entry) flattened for hazard reductions.
  always_comb begin
    entry_index = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_index[i*INDEX_W +: INDEX_W] = mem[i][WIDTH-1 -: INDEX_W];
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write port owner: ALU results win, long results queue behind
// them, and a starvation counter forces a FIFO drain after a bounded wait.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned REGISTER_NUMBER_LOG = writeback_arbiter_pkg::REGISTER_NUMBER_LOG,
  parameter int unsigned DATA_WIDTH          = writeback_arbiter_pkg::DATA_WIDTH,
  parameter int unsigned LONG_FIFO_DEPTH     = writeback_arbiter_pkg::LONG_FIFO_DEPTH,
  parameter int unsigned STARVE_LIMIT        = writeback_arbiter_pkg::STARVE_LIMIT
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                aluValid,
  input  logic [REGISTER_NUMBER_LOG-1:0]      aluIndex,
  input  logic [DATA_WIDTH-1:0]               aluValue,
  output logic                                aluStall,
  input  logic                                longValid,
  output logic                                longReady,
  input  logic [REGISTER_NUMBER_LOG-1:0]      longIndex,
  input  logic [DATA_WIDTH-1:0]               longValue,
  output logic                                writeEnable,
  output logic [REGISTER_NUMBER_LOG-1:0]      writeIndex,
  output logic [DATA_WIDTH-1:0]               writeValue,
  output logic [(1<<REGISTER_NUMBER_LOG)-1:0] pendingMask,
  output logic [clog2(LONG_FIFO_DEPTH):0]     fifoCount
);

  localparam int unsigned ENTRY_W = REGISTER_NUMBER_LOG + DATA_WIDTH;
  localparam int unsigned CNT_W   = clog2(LONG_FIFO_DEPTH) + 1;
  localparam int unsigned WAIT_W  = clog2(STARVE_LIMIT + 1);

  logic [ENTRY_W-1:0]                         head_data;
  logic [LONG_FIFO_DEPTH-1:0]                 entry_valid;
  logic [LONG_FIFO_DEPTH*REGISTER_NUMBER_LOG-1:0] entry_index;
  logic [WAIT_W-1:0]                          wait_count;
  logic                                       fifo_empty;
  logic                                       long_push;
  logic                                       pop_sel;
  logic                                       alu_sel;

  // Long-path queue; index-0 results complete the handshake but are not stored.
  wb_fifo #(
    .DEPTH   (LONG_FIFO_DEPTH),
    .WIDTH   (ENTRY_W),
    .INDEX_W (REGISTER_NUMBER_LOG)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (long_push),
    .push_data   ({longIndex, longValue}),
    .pop         (pop_sel),
    .head_data   (head_data),
    .count       (fifoCount),
    .entry_valid (entry_valid),
    .entry_index (entry_index)
  );

  assign fifo_empty = (fifoCount == '0);
  assign longReady  = (fifoCount < CNT_W'(LONG_FIFO_DEPTH));
  assign long_push  = longValid && longReady && (longIndex != '0);
  assign aluStall   = (wait_count == WAIT_W'(STARVE_LIMIT)) && !fifo_empty;

  // Source selection: forced drain, then ALU, then opportunistic drain.
  always_comb begin
    pop_sel = 1'b0;
    alu_sel = 1'b0;
    if (aluStall) begin
      pop_sel = 1'b1;
    end else if (aluValid && (aluIndex != '0)) begin
      alu_sel = 1'b1;
    end else if (!fifo_empty) begin
      pop_sel = 1'b1;
    end
  end

  // Registered write port; index and data held at zero when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      writeEnable <= 1'b0;
      writeIndex  <= '0;
      writeValue  <= '0;
    end else if (alu_sel) begin
      writeEnable <= 1'b1;
      writeIndex  <= aluIndex;
      writeValue  <= aluValue;
    end else if (pop_sel) begin
      writeEnable <= 1'b1;
      writeIndex  <= head_data[ENTRY_W-1 -: REGISTER_NUMBER_LOG];
      writeValue  <= head_data[DATA_WIDTH-1:0];
    end else begin
      writeEnable <= 1'b0;
      writeIndex  <= '0;
      writeValue  <= '0;
    end
  end

  // Cycles the current FIFO head has waited; saturates so the stall lasts one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_count <= '0;
    end else if (pop_sel || fifo_empty) begin
      wait_count <= '0;
    end else if (wait_count != WAIT_W'(STARVE_LIMIT)) begin
      wait_count <= wait_count + WAIT_W'(1);
    end
  end

  // Destinations of queued long results, for decode hazard checks.
  always_comb begin
    pendingMask = '0;
    for (int unsigned i = 0; i < LONG_FIFO_DEPTH; i++) begin
      if (entry_valid[i]) begin
        pendingMask[entry_index[i*REGISTER_NUMBER_LOG +: REGISTER_NUMBER_LOG]] = 1'b1;
      end
    end
    pendingMask[0] = 1'b0;
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed scoreboard bench for writeback_arbiter.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        aluValid;
  logic [4:0]  aluIndex;
  logic [31:0] aluValue;
  logic        aluStall;
  logic        longValid;
  logic        longReady;
  logic [4:0]  longIndex;
  logic [31:0] longValue;
  logic        writeEnable;
  logic [4:0]  writeIndex;
  logic [31:0] writeValue;
  logic [31:0] pendingMask;
  logic [2:0]  fifoCount;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  writeback_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .aluValid    (aluValid),
    .aluIndex    (aluIndex),
    .aluValue    (aluValue),
    .aluStall    (aluStall),
    .longValid   (longValid),
    .longReady   (longReady),
    .longIndex   (longIndex),
    .longValue   (longValue),
    .writeEnable (writeEnable),
    .writeIndex  (writeIndex),
    .writeValue  (writeValue),
    .pendingMask (pendingMask),
    .fifoCount   (fifoCount)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] i, input logic [31:0] d);
    aluValid = v;
    aluIndex = i;
    aluValue = d;
  endtask

  task automatic drive_long(input logic v, input logic [4:0] i, input logic [31:0] d);
    longValid = v;
    longIndex = i;
    longValue = d;
  endtask

  task automatic expect_write(input logic [4:0] i, input logic [31:0] d);
    exp_t e;
    e.idx = i;
    e.val = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every write must match the next expected entry; idle cycles must be zero.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset === 1'b1) begin
      if (writeEnable === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: actual idx=%0d val=0x%0h required no write at %0t",
                   writeIndex, writeValue, $time);
        end else begin
          e = exp_q.pop_front();
          chk("write_index", 64'(writeIndex), 64'(e.idx));
          chk("write_value", 64'(writeValue), 64'(e.val));
        end
      end else begin
        chk("idle_zero", 64'({writeIndex, writeValue}), 64'(0));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  logic [4:0] swap_idx [4] = '{5'd5, 5'd6, 5'd8, 5'd9};

  initial begin : stimulus
    int j;
    reset = 1'b0;
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_long(1'b0, 5'd0, 32'd0);

    // Reset state, then idle after release
    repeat (2) @(posedge clk);
    #1;
    chk("reset_write_enable", 64'(writeEnable), 64'(0));
    chk("reset_fifo_count", 64'(fifoCount), 64'(0));
    chk("reset_pending", 64'(pendingMask), 64'(0));
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_write_enable", 64'(writeEnable), 64'(0));
      chk("idle_write_index", 64'(writeIndex), 64'(0));
      chk("idle_long_ready", 64'(longReady), 64'(1));
      chk("idle_pending", 64'(pendingMask), 64'(0));
      @(posedge clk);
      #1;
    end

    // ALU only, then an index-0 ALU result
    drive_alu(1'b1, 5'd3, 32'hDEADBEEF);
    expect_write(5'd3, 32'hDEADBEEF);
    cyc();
    drive_alu(1'b1, 5'd0, 32'h12345678);
    @(negedge clk);
    chk("alu_write_enable", 64'(writeEnable), 64'(1));
    @(posedge clk);
    #1;
    drive_alu(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("alu_index0_no_write", 64'(writeEnable), 64'(0));
    @(posedge clk);
    #1;
    cyc();

    // Long result starved by continuous ALU traffic
    for (int k = 0; k <= 10; k++) begin
      j = (k <= 9) ? k : 9;
      drive_alu(1'b1, 5'(10 + j), 32'(32'h100 + j));
      drive_long(k == 0, 5'd7, 32'h11);
      if (k <= 8)       expect_write(5'(10 + k), 32'(32'h100 + k));
      else if (k == 9)  expect_write(5'd7, 32'h11);
      else              expect_write(5'd19, 32'h109);
      @(negedge clk);
      chk("starve_stall", 64'(aluStall), 64'(k == 9));
      if (k == 1)  chk("pending_bit7", 64'(pendingMask), 64'(32'h80));
      if (k == 10) chk("pending_clear", 64'(pendingMask), 64'(0));
      @(posedge clk);
      #1;
    end
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_long(1'b0, 5'd0, 32'd0);
    repeat (2) cyc();

    // Fill the FIFO under ALU traffic, refuse a fifth, drain in order
    for (int k = 0; k <= 10; k++) begin
      drive_alu(k <= 5, 5'(20 + k), 32'(32'h200 + k));
      if (k <= 3)      drive_long(1'b1, 5'(k + 1), 32'(32'hA000_0000 + k + 1));
      else if (k <= 5) drive_long(1'b1, 5'd5, 32'hA000_0005);
      else             drive_long(1'b0, 5'd0, 32'd0);
      if (k <= 5)      expect_write(5'(20 + k), 32'(32'h200 + k));
      else if (k <= 9) expect_write(5'(k - 5), 32'(32'hA000_0000 + k - 5));
      @(negedge clk);
      if (k == 4 || k == 5) begin
        chk("full_long_ready", 64'(longReady), 64'(0));
        chk("full_fifo_count", 64'(fifoCount), 64'(4));
        chk("full_pending", 64'(pendingMask), 64'(32'h1E));
      end
      if (k == 10) chk("drained_count", 64'(fifoCount), 64'(0));
      @(posedge clk);
      #1;
    end
    repeat (2) cyc();

    // Simultaneous push and pop with three entries queued
    for (int k = 0; k <= 7; k++) begin
      drive_alu(k <= 2, 5'(20 + k), 32'(32'h300 + k));
      if (k <= 3) drive_long(1'b1, swap_idx[k], 32'(32'hB000_0000 + swap_idx[k]));
      else        drive_long(1'b0, 5'd0, 32'd0);
      if (k <= 2)      expect_write(5'(20 + k), 32'(32'h300 + k));
      else if (k <= 6) expect_write(swap_idx[k-3], 32'(32'hB000_0000 + swap_idx[k-3]));
      @(negedge clk);
      if (k == 3) begin
        chk("swap_count_before", 64'(fifoCount), 64'(3));
        chk("swap_long_ready", 64'(longReady), 64'(1));
      end
      if (k == 4) begin
        chk("swap_count_after", 64'(fifoCount), 64'(3));
        chk("swap_old_head", 64'(writeIndex), 64'(5));
        chk("swap_pending", 64'(pendingMask), 64'(32'h340));
      end
      if (k == 7) chk("swap_drained", 64'(fifoCount), 64'(0));
      @(posedge clk);
      #1;
    end
    repeat (2) cyc();

    // Asynchronous reset while draining
    for (int k = 0; k <= 3; k++) begin
      drive_alu(k <= 2, 5'(20 + k), 32'(32'h400 + k));
      drive_long(1'b1, 5'(11 + k), 32'(32'hC000_0000 + 11 + k));
      if (k <= 2) expect_write(5'(20 + k), 32'(32'h400 + k));
      cyc();
    end
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_long(1'b0, 5'd0, 32'd0);
    chk("predrain_write_enable", 64'(writeEnable), 64'(1));
    chk("predrain_write_index", 64'(writeIndex), 64'(11));
    chk("predrain_count", 64'(fifoCount), 64'(3));
    #2;
    reset = 1'b0;
    #1;
    chk("async_write_enable", 64'(writeEnable), 64'(0));
    chk("async_write_index", 64'(writeIndex), 64'(0));
    chk("async_write_value", 64'(writeValue), 64'(0));
    chk("async_fifo_count", 64'(fifoCount), 64'(0));
    chk("async_pending", 64'(pendingMask), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_reset_write_enable", 64'(writeEnable), 64'(0));
      chk("post_reset_count", 64'(fifoCount), 64'(0));
      @(posedge clk);
      #1;
    end

    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writeback stage directly upstream of the register file; owns the register file's single write port (writeIndex/writeValue).
- Merges two result producers:
  - single-cycle ALU path, which has priority;
  - long-latency path (mul/div, load), buffered in a small FIFO.
- Exports a pending-write mask so decode can detect hazards against queued long results.

Parameters:
REGISTER_NUMBER_LOG, 5, register index width
DATA_WIDTH, 32, result width
LONG_FIFO_DEPTH, 4, long-path queue entries (power of two, >=2)
STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO head may wait before ALU is stalled

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset asserted
aluValid  in  1  ALU result present this cycle
aluIndex  in  REGISTER_NUMBER_LOG  ALU destination register
aluValue  in  DATA_WIDTH  ALU result
aluStall  out  1  ALU result not taken this cycle; upstream must hold aluValid/aluIndex/aluValue
longValid  in  1  long-path result offered
longReady  out  1  long-path result accepted when longValid && longReady
longIndex  in  REGISTER_NUMBER_LOG  long-path destination
longValue  in  DATA_WIDTH  long-path result
writeEnable  out  1  registered: write performed this cycle
writeIndex  out  REGISTER_NUMBER_LOG  registered write index; 0 when writeEnable=0
writeValue  out  DATA_WIDTH  registered write data; 0 when writeEnable=0
pendingMask  out  2^REGISTER_NUMBER_LOG  bit r set iff a queued FIFO entry targets r (bit 0 always 0)
fifoCount  out  clog2(LONG_FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (reset=0, async):
  - writeEnable=0, writeIndex=0, writeValue=0;
  - FIFO empty, fifoCount=0, pendingMask=0;
  - waitCount=0, aluStall=0, longReady=1 once reset deasserts.
- Reset mid-operation discards all queued and in-flight results.
- Index 0 writes are discarded:
  - ALU: result with aluIndex=0 is consumed, produces no write, and does not block the FIFO.
  - Long path: handshake completes but nothing is enqueued.
- longReady = (fifoCount < LONG_FIFO_DEPTH), computed from registered state only; no same-cycle pass-through when full.
- Selection each cycle (combinational; result registered at the next rising edge, latency 1):
  - aluStall = (waitCount == STARVE_LIMIT) && FIFO non-empty.
  - If aluStall: pop FIFO head to output; the ALU input is ignored this cycle.
  - Else if aluValid && aluIndex != 0: ALU to output.
  - Else if FIFO non-empty: pop head to output.
  - Else: writeEnable=0, writeIndex=0, writeValue=0.
- waitCount:
  - resets to 0 on any pop or when the FIFO is empty;
  - otherwise increments, saturating at STARVE_LIMIT.
  - Result: aluStall is high exactly one cycle per starvation event.
- Push and pop in the same cycle are both allowed (subject to longReady); fifoCount stays unchanged.
- FIFO pointers wrap modulo LONG_FIFO_DEPTH; order is strict FIFO.
- pendingMask is the OR of one-hot(index) over valid entries, computed combinationally from FIFO state.
  - A just-accepted entry appears the cycle after acceptance.
  - A popped entry disappears the cycle it moves to the output register.
- WAW ordering between paths is not resolved here; decode must not issue an ALU op to a register whose pendingMask bit is set.
- writeIndex is forced to 0 whenever writeEnable=0, so the register file never sees a spurious index change.

Decomposition:
- Shared package/include: REGISTER_NUMBER_LOG, REGISTER_NUMBER, DATA_WIDTH, clog2 helper.
- Sub-module: wb_fifo, a generic synchronous FIFO.
  - Parameters: depth, width.
  - Signals: push, pop, count, plus a flat view of entry valid bits and indices for the pendingMask reduction.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release; for 5 cycles require writeEnable=0, writeIndex=0, longReady=1, pendingMask=0.
- ALU only: aluValid with index 3, value 0xDEADBEEF -> next cycle writeEnable=1, writeIndex=3, writeValue=0xDEADBEEF.
  - Same stimulus with index 0 -> no write.
- Long path queued under ALU traffic:
  - push long (7, 0x11) while ALU issues every cycle -> pendingMask bit 7 set.
  - After STARVE_LIMIT=8 waiting cycles, aluStall=1 for exactly one cycle, then (7, 0x11) is written and bit 7 clears.
- FIFO full: push 4 long results with no pops (ALU busy) -> longReady=0, fifoCount=4.
  - A 5th offer is not accepted.
  - Drain order matches push order (1, 2, 3, 4).
- Simultaneous push/pop with FIFO at 3: aluValid=0, push 1 -> fifoCount stays 3, output shows old head.
- Reset mid-drain: FIFO holds 3 entries; assert reset asynchronously between edges -> outputs 0 immediately, fifoCount=0, no writes after release.
